// File: rtl/ram_port_arb_pkg.sv
// Shared definitions for the RAM port arbiter: grant-state encoding and
// round-robin source constants.
package ram_port_arb_pkg;

    typedef enum logic [1:0] {
        GntIdle = 2'd0,
        GntCtrl = 2'd1,
        GntSamp = 2'd2,
        GntHost = 2'd3
    } gnt_e;

    typedef enum logic {
        SrcSamp = 1'b0,
        SrcHost = 1'b1
    } src_e;

    function automatic src_e src_flip(src_e s);
        return (s == SrcSamp) ? SrcHost : SrcSamp;
    endfunction

endpackage

// File: rtl/ram_port_arb_if.sv
// Controller, sample and host handshake signals of the RAM port arbiter.
// master = requesters side, slave = arbiter side.
interface ram_port_arb_if #(
    parameter int unsigned DATA_ADDR_WIDTH = 4,
    parameter int unsigned DATA_WIDTH      = 16
) ();

    logic                       ctrl_en;
    logic [DATA_ADDR_WIDTH-1:0] ctrl_addr;
    logic                       ctrl_rvalid;

    logic                       s_valid;
    logic [DATA_WIDTH-1:0]      s_data;
    logic                       s_ready;

    logic                       h_valid;
    logic                       h_wr;
    logic [DATA_ADDR_WIDTH-1:0] h_addr;
    logic [DATA_WIDTH-1:0]      h_data;
    logic                       h_ready;
    logic                       h_rvalid;
    logic [DATA_WIDTH-1:0]      h_rdata;

    modport master (
        output ctrl_en, ctrl_addr, s_valid, s_data, h_valid, h_wr, h_addr, h_data,
        input  ctrl_rvalid, s_ready, h_ready, h_rvalid, h_rdata
    );

    modport slave (
        input  ctrl_en, ctrl_addr, s_valid, s_data, h_valid, h_wr, h_addr, h_data,
        output ctrl_rvalid, s_ready, h_ready, h_rvalid, h_rdata
    );

endinterface

// File: rtl/ctrl_sfifo.sv
// Two-entry sample FIFO. Caller guarantees no push when full and no pop when empty.
module ctrl_sfifo #(
    parameter int unsigned Width = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [Width-1:0] wdata_i,
    input  logic             pop_i,
    output logic [Width-1:0] rdata_o,
    output logic             empty_o,
    output logic             full_o
);

    logic [Width-1:0] mem_q [2];
    logic [Width-1:0] mem_d [2];
    logic             wr_ptr_q, wr_ptr_d;
    logic             rd_ptr_q, rd_ptr_d;
    logic [1:0]       cnt_q, cnt_d;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (push_i) begin
            mem_d[wr_ptr_q] = wdata_i;
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (pop_i) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        case ({push_i, pop_i})
            2'b10:   cnt_d = cnt_q + 2'd1;
            2'b01:   cnt_d = cnt_q - 2'd1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            cnt_q    <= 2'd0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign empty_o = (cnt_q == 2'd0);
    assign full_o  = (cnt_q == 2'd2);

endmodule

// File: rtl/ram_port_arb.sv
// Single-port RAM arbiter: controller reads win outright; buffered samples
// and host accesses share the remaining cycles round-robin.
module ram_port_arb
    import ram_port_arb_pkg::*;
#(
    parameter int unsigned DATA_ADDR_WIDTH = 4,
    parameter int unsigned DATA_WIDTH      = 16,
    parameter int unsigned BUF_LEN         = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    ram_port_arb_if.slave              bus,
    output logic                       ram_en,
    output logic                       ram_wr,
    output logic [DATA_ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0]      ram_wdata,
    input  logic [DATA_WIDTH-1:0]      ram_rdata,
    output logic [DATA_ADDR_WIDTH-1:0] wptr,
    output logic                       new_in
);

    localparam logic [DATA_ADDR_WIDTH-1:0] WptrLast = DATA_ADDR_WIDTH'(BUF_LEN - 1);

    gnt_e                       gnt_d, gnt_q;
    src_e                       rr_d, rr_q;
    logic [DATA_ADDR_WIDTH-1:0] wptr_d, wptr_q;
    logic                       hrd_d, hrd_q;

    logic                  fifo_push, fifo_pop, fifo_empty, fifo_full;
    logic [DATA_WIDTH-1:0] fifo_head;

    ctrl_sfifo #(
        .Width (DATA_WIDTH)
    ) u_sfifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (fifo_push),
        .wdata_i (bus.s_data),
        .pop_i   (fifo_pop),
        .rdata_o (fifo_head),
        .empty_o (fifo_empty),
        .full_o  (fifo_full)
    );

    assign bus.s_ready = ~fifo_full;
    assign fifo_push   = bus.s_valid & ~fifo_full;
    assign fifo_pop    = (gnt_d == GntSamp);

    // Grant decision; forced idle under reset so no write can slip through.
    always_comb begin
        gnt_d = GntIdle;
        if (rst) begin
            gnt_d = GntIdle;
        end else if (bus.ctrl_en) begin
            gnt_d = GntCtrl;
        end else if (!fifo_empty && bus.h_valid) begin
            gnt_d = (rr_q == SrcSamp) ? GntSamp : GntHost;
        end else if (!fifo_empty) begin
            gnt_d = GntSamp;
        end else if (bus.h_valid) begin
            gnt_d = GntHost;
        end
    end

    always_comb begin
        ram_en      = 1'b0;
        ram_wr      = 1'b0;
        ram_addr    = '0;
        ram_wdata   = '0;
        bus.h_ready = 1'b0;
        new_in      = 1'b0;
        rr_d        = rr_q;
        wptr_d      = wptr_q;
        hrd_d       = 1'b0;
        unique case (gnt_d)
            GntCtrl: begin
                ram_en   = 1'b1;
                ram_addr = bus.ctrl_addr;
            end
            GntSamp: begin
                ram_en    = 1'b1;
                ram_wr    = 1'b1;
                ram_addr  = wptr_q;
                ram_wdata = fifo_head;
                new_in    = 1'b1;
                rr_d      = src_flip(rr_q);
                wptr_d    = (wptr_q == WptrLast) ? '0 : wptr_q + 1'b1;
            end
            GntHost: begin
                ram_en      = 1'b1;
                ram_wr      = bus.h_wr;
                ram_addr    = bus.h_addr;
                ram_wdata   = bus.h_wr ? bus.h_data : '0;
                bus.h_ready = 1'b1;
                rr_d        = src_flip(rr_q);
                hrd_d       = ~bus.h_wr;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            gnt_q  <= GntIdle;
            rr_q   <= SrcSamp;
            wptr_q <= '0;
            hrd_q  <= 1'b0;
        end else begin
            gnt_q  <= gnt_d;
            rr_q   <= rr_d;
            wptr_q <= wptr_d;
            hrd_q  <= hrd_d;
        end
    end

    // Read valids are masked during reset so an in-flight read is dropped.
    assign bus.ctrl_rvalid = (gnt_q == GntCtrl) & ~rst;
    assign bus.h_rvalid    = (gnt_q == GntHost) & hrd_q & ~rst;
    assign bus.h_rdata     = ram_rdata;
    assign wptr            = wptr_q;

endmodule

// File: tb/tb_ram_port_arb.sv
// Directed bench for ram_port_arb: per-cycle vector table plus hand-written
// wrap and mid-operation reset sequences, against a behavioural 1-cycle RAM.
module tb_ram_port_arb;

    logic        clk = 1'b0;
    logic        rst;
    logic        ram_en, ram_wr, new_in;
    logic [3:0]  ram_addr, wptr;
    logic [15:0] ram_wdata;
    logic [15:0] ram_rdata = '0;

    ram_port_arb_if #(.DATA_ADDR_WIDTH(4), .DATA_WIDTH(16)) bus ();

    ram_port_arb #(
        .DATA_ADDR_WIDTH (4),
        .DATA_WIDTH      (16),
        .BUF_LEN         (16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .ram_en    (ram_en),
        .ram_wr    (ram_wr),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata),
        .wptr      (wptr),
        .new_in    (new_in)
    );

    always #5 clk = ~clk;

    logic [15:0] ram_mem [16];
    logic        mem_init = 1'b0;

    always @(posedge clk) begin
        if (!mem_init) begin
            for (int i = 0; i < 16; i++) ram_mem[i] <= '0;
            mem_init <= 1'b1;
        end else if (ram_en) begin
            if (ram_wr) ram_mem[ram_addr] <= ram_wdata;
            else        ram_rdata <= ram_mem[ram_addr];
        end
    end

    typedef struct {
        logic        rst;
        logic        ce;
        logic [3:0]  ca;
        logic        sv;
        logic [15:0] sd;
        logic        hv;
        logic        hw;
        logic [3:0]  ha;
        logic [15:0] hd;
        logic [46:0] exp;
    } vec_t;

    vec_t vecs[$];
    int   n_vec = 0;
    int   n_err = 0;

    // {ram_en, ram_wr, ram_addr, ram_wdata, s_ready, h_ready, new_in, wptr,
    //  ctrl_rvalid, h_rvalid, h_rdata}
    function automatic logic [46:0] e(logic en, logic wr, logic [3:0] a, logic [15:0] wd,
                                      logic sr, logic hr, logic ni, logic [3:0] wp,
                                      logic cv, logic hv, logic [15:0] rd);
        return {en, wr, a, wd, sr, hr, ni, wp, cv, hv, rd};
    endfunction

    task automatic add(input logic r, input logic ce, input logic [3:0] ca, input logic sv,
                       input logic [15:0] sd, input logic hv, input logic hw,
                       input logic [3:0] ha, input logic [15:0] hd, input logic [46:0] ex);
        vec_t v;
        v = '{rst: r, ce: ce, ca: ca, sv: sv, sd: sd, hv: hv, hw: hw, ha: ha, hd: hd, exp: ex};
        vecs.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        rst           = v.rst;
        bus.ctrl_en   = v.ce;
        bus.ctrl_addr = v.ca;
        bus.s_valid   = v.sv;
        bus.s_data    = v.sd;
        bus.h_valid   = v.hv;
        bus.h_wr      = v.hw;
        bus.h_addr    = v.ha;
        bus.h_data    = v.hd;
    endtask

    function automatic logic [46:0] outs();
        return {ram_en, ram_wr, ram_addr, ram_wdata, bus.s_ready, bus.h_ready, new_in, wptr,
                bus.ctrl_rvalid, bus.h_rvalid, bus.h_rdata};
    endfunction

    int sent;
    int nw;

    initial begin
        vec_t idle_v;
        idle_v = '{rst: 1'b0, ce: 1'b0, ca: '0, sv: 1'b0, sd: '0, hv: 1'b0, hw: 1'b0,
                   ha: '0, hd: '0, exp: '0};

        // Reset state, three back-to-back samples.
        add(0, 0, 4'h0, 0, 16'h0000, 0, 0, 4'h0, 16'h0, e(0, 0, 4'h0, 16'h0000, 1, 0, 0, 4'h0, 0, 0, 16'h0000));
        add(0, 0, 4'h0, 1, 16'h0011, 0, 0, 4'h0, 16'h0, e(0, 0, 4'h0, 16'h0000, 1, 0, 0, 4'h0, 0, 0, 16'h0000));
        add(0, 0, 4'h0, 1, 16'h0022, 0, 0, 4'h0, 16'h0, e(1, 1, 4'h0, 16'h0011, 1, 0, 1, 4'h0, 0, 0, 16'h0000));
        add(0, 0, 4'h0, 1, 16'h0033, 0, 0, 4'h0, 16'h0, e(1, 1, 4'h1, 16'h0022, 1, 0, 1, 4'h1, 0, 0, 16'h0000));
        add(0, 0, 4'h0, 0, 16'h0000, 0, 0, 4'h0, 16'h0, e(1, 1, 4'h2, 16'h0033, 1, 0, 1, 4'h2, 0, 0, 16'h0000));
        add(0, 0, 4'h0, 0, 16'h0000, 0, 0, 4'h0, 16'h0, e(0, 0, 4'h0, 16'h0000, 1, 0, 0, 4'h3, 0, 0, 16'h0000));
        // Controller holds the port 5 cycles while samples back up.
        add(0, 1, 4'h1, 1, 16'h00a1, 0, 0, 4'h0, 16'h0, e(1, 0, 4'h1, 16'h0000, 1, 0, 0, 4'h3, 0, 0, 16'h0000));
        add(0, 1, 4'h8, 1, 16'h00a2, 0, 0, 4'h0, 16'h0, e(1, 0, 4'h8, 16'h0000, 1, 0, 0, 4'h3, 1, 0, 16'h0022));
        add(0, 1, 4'h9, 1, 16'h00a3, 0, 0, 4'h0, 16'h0, e(1, 0, 4'h9, 16'h0000, 0, 0, 0, 4'h3, 1, 0, 16'h0000));
        add(0, 1, 4'ha, 1, 16'h00a3, 0, 0, 4'h0, 16'h0, e(1, 0, 4'ha, 16'h0000, 0, 0, 0, 4'h3, 1, 0, 16'h0000));
        add(0, 1, 4'hb, 1, 16'h00a3, 0, 0, 4'h0, 16'h0, e(1, 0, 4'hb, 16'h0000, 0, 0, 0, 4'h3, 1, 0, 16'h0000));
        add(0, 0, 4'h0, 0, 16'h0000, 0, 0, 4'h0, 16'h0, e(1, 1, 4'h3, 16'h00a1, 0, 0, 1, 4'h3, 1, 0, 16'h0000));
        add(0, 0, 4'h0, 0, 16'h0000, 0, 0, 4'h0, 16'h0, e(1, 1, 4'h4, 16'h00a2, 1, 0, 1, 4'h4, 0, 0, 16'h0000));
        add(0, 0, 4'h0, 0, 16'h0000, 0, 0, 4'h0, 16'h0, e(0, 0, 4'h0, 16'h0000, 1, 0, 0, 4'h5, 0, 0, 16'h0000));
        // Host write then read of address 5; no rvalid after the write.
        add(0, 0, 4'h0, 0, 16'h0000, 1, 1, 4'h5, 16'hbeef, e(1, 1, 4'h5, 16'hbeef, 1, 1, 0, 4'h5, 0, 0, 16'h0000));
        add(0, 0, 4'h0, 0, 16'h0000, 1, 0, 4'h5, 16'h0000, e(1, 0, 4'h5, 16'h0000, 1, 1, 0, 4'h5, 0, 0, 16'h0000));
        add(0, 0, 4'h0, 0, 16'h0000, 0, 0, 4'h0, 16'h0000, e(0, 0, 4'h0, 16'h0000, 1, 0, 0, 4'h5, 0, 1, 16'hbeef));
        // Controller read, then reset cycle masks its rvalid.
        add(0, 1, 4'h0, 0, 16'h0000, 0, 0, 4'h0, 16'h0000, e(1, 0, 4'h0, 16'h0000, 1, 0, 0, 4'h5, 0, 0, 16'hbeef));
        add(1, 0, 4'h0, 0, 16'h0000, 0, 0, 4'h0, 16'h0000, e(0, 0, 4'h0, 16'h0000, 1, 0, 0, 4'h5, 0, 0, 16'h0011));
        // Sample vs host read of address 5: SAMP, HOST, SAMP, HOST, SAMP, SAMP.
        add(0, 0, 4'h0, 1, 16'h0101, 0, 0, 4'h0, 16'h0000, e(0, 0, 4'h0, 16'h0000, 1, 0, 0, 4'h0, 0, 0, 16'h0011));
        add(0, 0, 4'h0, 1, 16'h0202, 1, 0, 4'h5, 16'h0000, e(1, 1, 4'h0, 16'h0101, 1, 0, 1, 4'h0, 0, 0, 16'h0011));
        add(0, 0, 4'h0, 1, 16'h0303, 1, 0, 4'h5, 16'h0000, e(1, 0, 4'h5, 16'h0000, 1, 1, 0, 4'h1, 0, 0, 16'h0011));
        add(0, 0, 4'h0, 1, 16'h0404, 1, 0, 4'h5, 16'h0000, e(1, 1, 4'h1, 16'h0202, 0, 0, 1, 4'h1, 0, 1, 16'hbeef));
        add(0, 0, 4'h0, 1, 16'h0404, 1, 0, 4'h5, 16'h0000, e(1, 0, 4'h5, 16'h0000, 1, 1, 0, 4'h2, 0, 0, 16'hbeef));
        add(0, 0, 4'h0, 0, 16'h0000, 0, 0, 4'h0, 16'h0000, e(1, 1, 4'h2, 16'h0303, 0, 0, 1, 4'h2, 0, 1, 16'hbeef));
        add(0, 0, 4'h0, 0, 16'h0000, 0, 0, 4'h0, 16'h0000, e(1, 1, 4'h3, 16'h0404, 1, 0, 1, 4'h3, 0, 0, 16'hbeef));
        add(0, 0, 4'h0, 0, 16'h0000, 0, 0, 4'h0, 16'h0000, e(0, 0, 4'h0, 16'h0000, 1, 0, 0, 4'h4, 0, 0, 16'hbeef));

        drive(idle_v);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        for (int i = 0; i < vecs.size(); i++) begin
            #1;
            drive(vecs[i]);
            @(negedge clk);
            n_vec++;
            if (outs() !== vecs[i].exp) begin
                n_err++;
                $display("FAIL vec%0d: got %h want %h", i, outs(), vecs[i].exp);
            end
            @(posedge clk);
        end

        // 17 samples into a 16-deep buffer: 17th lands at address 0.
        #1;
        drive(idle_v);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst  = 1'b0;
        sent = 0;
        nw   = 0;
        for (int cyc = 0; cyc < 40 && nw < 17; cyc++) begin
            bus.s_valid = (sent < 17);
            bus.s_data  = 16'(32'h1000 + sent);
            @(negedge clk);
            if (new_in) begin
                chk($sformatf("wrap_addr%0d", nw), 64'(ram_addr), 64'(nw % 16));
                chk($sformatf("wrap_data%0d", nw), 64'(ram_wdata), 64'(32'h1000 + nw));
                nw++;
            end
            if (bus.s_valid && bus.s_ready) sent++;
            @(posedge clk);
            #1;
        end
        bus.s_valid = 1'b0;
        chk("wrap_count", 64'(nw), 64'd17);
        @(negedge clk);
        chk("wrap_wptr", 64'(wptr), 64'd1);

        // Reset with two buffered samples and a host read in flight.
        @(posedge clk);
        #1;
        bus.ctrl_en   = 1'b1;
        bus.ctrl_addr = 4'h2;
        bus.s_valid   = 1'b1;
        bus.s_data    = 16'haaaa;
        @(negedge clk);
        chk("rst_fill1_ready", 64'(bus.s_ready), 64'd1);
        @(posedge clk);
        #1;
        bus.s_data = 16'hbbbb;
        @(negedge clk);
        chk("rst_fill2_ready", 64'(bus.s_ready), 64'd1);
        @(posedge clk);
        #1;
        bus.ctrl_en = 1'b0;
        bus.s_valid = 1'b0;
        bus.h_valid = 1'b1;
        bus.h_wr    = 1'b0;
        bus.h_addr  = 4'h5;
        @(negedge clk);
        chk("rst_host_grant", 64'({bus.h_ready, ram_en, ram_wr}), 64'b110);
        @(posedge clk);
        #1;
        bus.h_valid = 1'b0;
        rst         = 1'b1;
        @(negedge clk);
        chk("rst_cycle_quiet", 64'({ram_en, ram_wr, new_in, bus.h_rvalid}), 64'b0000);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_wptr", 64'(wptr), 64'd0);
        chk("post_rst_sready", 64'(bus.s_ready), 64'd1);
        chk("post_rst_quiet", 64'({ram_en, ram_wr, new_in, bus.h_rvalid}), 64'b0000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
